cap_centroid: RTL

Downstream consumer of the camera capture stream (`cap_en`/`cap_addr_x`/`cap_addr_y`/`cap_dout`, RGB565, 320x240, system clock domain). It thresholds each pixel against a programmable RGB565 colour box and accumulates hit count and coordinate sums over one frame. At frame end it computes the integer centroid with a serial divider and presents `{found, cx, cy, count}` on a valid/ready port to the steering controller.

---
 rtl/cap_centroid_pkg.sv | 34 +++
 rtl/cap_centroid_serial_div.sv | 77 +++++++
 rtl/cap_centroid.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cap_centroid_pkg.sv
// Shared definitions for the colour-box centroid tracker: RGB565 field
// positions, accumulator/divider widths and the result FSM states.
package cap_centroid_pkg;

   localparam int unsigned R_MSB = 15;
   localparam int unsigned R_LSB = 11;
   localparam int unsigned G_MSB = 10;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_MSB = 4;
   localparam int unsigned B_LSB = 0;

   localparam int unsigned COORD_W   = 10;
   localparam int unsigned CNT_W     = 17;
   localparam int unsigned SUM_W     = 25;
   localparam int unsigned DIV_ITER  = 25;
   localparam int unsigned DIV_CNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIV_X,
      ST_DIV_Y,
      ST_HOLD
   } state_t;

   // Per-channel unsigned inclusive box test at native 5/6/5 widths
   function automatic logic rgb_in_box(input logic [15:0] pix,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
      return (pix[R_MSB:R_LSB] >= lo[R_MSB:R_LSB]) && (pix[R_MSB:R_LSB] <= hi[R_MSB:R_LSB]) &&
             (pix[G_MSB:G_LSB] >= lo[G_MSB:G_LSB]) && (pix[G_MSB:G_LSB] <= hi[G_MSB:G_LSB]) &&
             (pix[B_MSB:B_LSB] >= lo[B_MSB:B_LSB]) && (pix[B_MSB:B_LSB] <= hi[B_MSB:B_LSB]);
   endfunction

endpackage

// File: rtl/cap_centroid_serial_div.sv
// Restoring serial divider, one quotient bit per cycle. The first iteration
// is taken on the start cycle directly from the operands, so done pulses
// exactly DIV_ITER cycles after start with the quotient already settled.
module serial_div
   import cap_centroid_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [SUM_W-1:0]   i_dividend,
   input  logic [CNT_W-1:0]   i_divisor,
   output logic               o_busy,
   output logic               o_done,
   output logic [COORD_W-1:0] o_quotient
);

   logic [SUM_W-1:0]     r_dvd;
   logic [CNT_W-1:0]     r_rem;
   logic [CNT_W-1:0]     r_dvs;
   logic [DIV_CNT_W-1:0] r_cnt;
   logic                 r_busy;
   logic                 r_done;

   logic [SUM_W-1:0]     w_dvd;
   logic [CNT_W-1:0]     w_rem;
   logic [CNT_W-1:0]     w_dvs;
   logic [CNT_W:0]       w_trial;
   logic [CNT_W:0]       w_diff;
   logic                 w_ge;
   logic [CNT_W-1:0]     w_rem_nxt;

   // One restoring step; remainder stays below the divisor so the sign of
   // the 18-bit trial difference decides the quotient bit.
   always_comb begin
      w_dvd     = i_start ? i_dividend : r_dvd;
      w_rem     = i_start ? '0 : r_rem;
      w_dvs     = i_start ? i_divisor : r_dvs;
      w_trial   = {w_rem, w_dvd[SUM_W-1]};
      w_diff    = w_trial - {1'b0, w_dvs};
      w_ge      = ~w_diff[CNT_W];
      w_rem_nxt = w_ge ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
   end

   // Shift register holds the remaining dividend bits and collects quotient bits
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dvd  <= '0;
         r_rem  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start || r_busy) begin
            r_dvd <= {w_dvd[SUM_W-2:0], w_ge};
            r_rem <= w_rem_nxt;
         end
         if (i_start) begin
            r_dvs  <= i_divisor;
            r_cnt  <= DIV_CNT_W'(DIV_ITER - 1);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_cnt <= r_cnt - DIV_CNT_W'(1);
            if (r_cnt == DIV_CNT_W'(1)) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_quotient = r_dvd[COORD_W-1:0];

endmodule

// File: rtl/cap_centroid.sv
// Colour-box centroid tracker on the capture stream: threshold, accumulate
// hit count and coordinate sums per frame, divide at frame end, and hold
// {found, cx, cy, count} on a valid/ready port.
module cap_centroid
   import cap_centroid_pkg::*;
#(
   parameter int unsigned H_RES     = 320,
   parameter int unsigned V_RES     = 240,
   parameter int unsigned MIN_COUNT = 64
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic        cap_en,
   input  logic [9:0]  cap_addr_x,
   input  logic [9:0]  cap_addr_y,
   input  logic [15:0] cap_dout,
   input  logic [15:0] thr_lo,
   input  logic [15:0] thr_hi,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [9:0]  res_cx,
   output logic [9:0]  res_cy,
   output logic [16:0] res_count,
   output logic        res_found,
   output logic        res_overrun
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_RES - 1);

   logic [15:0]        r_thr_lo;
   logic [15:0]        r_thr_hi;
   logic               r_s1_vld;
   logic               r_s1_hit;
   logic [COORD_W-1:0] r_s1_x;
   logic [COORD_W-1:0] r_s1_y;
   logic [CNT_W-1:0]   r_acc_cnt;
   logic [SUM_W-1:0]   r_acc_sx;
   logic [SUM_W-1:0]   r_acc_sy;
   logic [CNT_W-1:0]   r_snap_cnt;
   logic [SUM_W-1:0]   r_snap_sx;
   logic [SUM_W-1:0]   r_snap_sy;
   logic               r_fe;
   logic               r_sticky;
   state_t             r_state;
   state_t             w_state_nxt;

   logic               w_in_fe;
   logic               w_s1_first;
   logic               w_s1_fe;
   logic               w_accept;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [SUM_W-1:0]   w_sx_nxt;
   logic [SUM_W-1:0]   w_sy_nxt;
   logic               w_div_start;
   logic [SUM_W-1:0]   w_div_dvd;
   logic               w_div_busy;
   logic               w_div_done;
   logic [COORD_W-1:0] w_div_quo;
   logic               w_load;

   assign w_in_fe    = cap_en && (cap_addr_x == X_LAST) && (cap_addr_y == Y_LAST);
   assign w_s1_first = r_s1_vld && (r_s1_x == '0) && (r_s1_y == '0);
   assign w_s1_fe    = r_s1_vld && (r_s1_x == X_LAST) && (r_s1_y == Y_LAST);
   // A frame end is taken only when nothing is in flight; otherwise dropped
   assign w_accept   = (r_state == ST_IDLE) && !r_fe && !w_div_busy;

   // Stage 1: register pixel position and hit; shadows follow at each frame end
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_thr_lo <= '0;
         r_thr_hi <= '1;
         r_s1_vld <= 1'b0;
         r_s1_hit <= 1'b0;
         r_s1_x   <= '0;
         r_s1_y   <= '0;
      end else begin
         r_s1_vld <= cap_en;
         if (cap_en) begin
            r_s1_x   <= cap_addr_x;
            r_s1_y   <= cap_addr_y;
            r_s1_hit <= rgb_in_box(cap_dout, r_thr_lo, r_thr_hi);
         end
         if (w_in_fe) begin
            r_thr_lo <= thr_lo;
            r_thr_hi <= thr_hi;
         end
      end
   end

   // Next accumulator values; a (0,0) pixel restarts the sums before adding itself
   always_comb begin
      w_cnt_nxt = w_s1_first ? '0 : r_acc_cnt;
      w_sx_nxt  = w_s1_first ? '0 : r_acc_sx;
      w_sy_nxt  = w_s1_first ? '0 : r_acc_sy;
      if (r_s1_vld && r_s1_hit) begin
         w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
         w_sx_nxt  = w_sx_nxt + SUM_W'(r_s1_x);
         w_sy_nxt  = w_sy_nxt + SUM_W'(r_s1_y);
      end
   end

   // Stage 2: accumulate, snapshot on an accepted frame end, clear at every frame end
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_acc_cnt  <= '0;
         r_acc_sx   <= '0;
         r_acc_sy   <= '0;
         r_snap_cnt <= '0;
         r_snap_sx  <= '0;
         r_snap_sy  <= '0;
         r_fe       <= 1'b0;
      end else begin
         if (r_s1_vld) begin
            r_acc_cnt <= w_s1_fe ? '0 : w_cnt_nxt;
            r_acc_sx  <= w_s1_fe ? '0 : w_sx_nxt;
            r_acc_sy  <= w_s1_fe ? '0 : w_sy_nxt;
         end
         if (w_s1_fe && w_accept) begin
            r_snap_cnt <= w_cnt_nxt;
            r_snap_sx  <= w_sx_nxt;
            r_snap_sy  <= w_sy_nxt;
         end
         r_fe <= w_s1_fe && w_accept;
      end
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state, divider sequencing (x then y) and result load strobe
   always_comb begin
      w_state_nxt = r_state;
      w_div_start = 1'b0;
      w_div_dvd   = r_snap_sx;
      w_load      = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_fe) begin
               if (r_snap_cnt != '0) begin
                  w_div_start = 1'b1;
                  w_state_nxt = ST_DIV_X;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_HOLD;
               end
            end
         end
         ST_DIV_X: begin
            if (w_div_done) begin
               w_div_start = 1'b1;
               w_div_dvd   = r_snap_sy;
               w_state_nxt = ST_DIV_Y;
            end
         end
         ST_DIV_Y: begin
            if (w_div_done) begin
               w_load      = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (res_valid && res_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   serial_div u_div (
      .i_clk      (CLK),
      .i_rst_n    (RST_X),
      .i_start    (w_div_start),
      .i_dividend (w_div_dvd),
      .i_divisor  (r_snap_cnt),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quotient (w_div_quo)
   );

   // Output registers and the sticky dropped-frame flag
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         res_valid   <= 1'b0;
         res_cx      <= '0;
         res_cy      <= '0;
         res_count   <= '0;
         res_found   <= 1'b0;
         res_overrun <= 1'b0;
         r_sticky    <= 1'b0;
      end else begin
         if (w_s1_fe && !w_accept) begin
            r_sticky <= 1'b1;
         end else if (w_load) begin
            r_sticky <= 1'b0;
         end
         if ((r_state == ST_DIV_X) && w_div_done) begin
            res_cx <= w_div_quo;
         end else if (w_load && (r_state == ST_IDLE)) begin
            res_cx <= '0;
         end
         if (w_load) begin
            res_valid   <= 1'b1;
            res_count   <= r_snap_cnt;
            res_found   <= (r_snap_cnt >= CNT_W'(MIN_COUNT));
            res_overrun <= r_sticky;
            res_cy      <= (r_state == ST_IDLE) ? '0 : w_div_quo;
         end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule
